seq_det_scheduler: RTL
======================

# seq_det_scheduler

Round-robin scheduler that shares one 101/110 serial pattern detector among NUM_REQ requesters. Each requester hands over a FRAME_W-bit frame with a valid/ready handshake. The block clears the detector, shifts the frame in MSB-first one bit per clock, and counts detections. It then returns the count, tagged with the requester index, on a valid/ready result port. It sits between the frame sources and the detector, which is instantiated inside it.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- FRAME_W, 8, bits per frame
- CNT_W, 4, detection-count width (saturating)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester frame valid
- req_data  in  NUM_REQ*FRAME_W  frames; requester i occupies bits [i*FRAME_W +: FRAME_W]
- req_ready  out  NUM_REQ  one-hot accept strobe
- res_valid  out  1  result available
- res_id  out  $clog2(NUM_REQ)  index of the requester whose frame produced the result
- res_count  out  CNT_W  detections in that frame
- res_ready  in  1  consumer accepts result
- busy  out  1  high in every state except IDLE

## Operation
- FSM states are IDLE, CLEAR, SHIFT, DONE.
- **IDLE**
  - If any req_valid is high, grant the first valid requester searching from last_grant+1 and wrapping modulo NUM_REQ.
  - In the same cycle, drive req_ready for the granted requester only (combinational). Capture its frame into the shift register, record grant_id, zero the counter, and go to CLEAR.
  - If no req_valid is high, stay in IDLE.
- **CLEAR**: assert the detector's synchronous clear for one cycle, then go to SHIFT.
- **SHIFT**
  - Present shift_reg[FRAME_W-1] to the detector, then shift left.
  - The bit counter runs 0..FRAME_W-1. After the last bit, go to DONE.
  - While in SHIFT, each cycle with det_hit=1 increments the count. The count saturates at 2^CNT_W-1.
- **DONE**
  - res_valid=1. res_id and res_count are held stable.
  - When res_valid && res_ready, load last_grant with grant_id and return to IDLE. No new grant occurs in that cycle.
- Detector behaviour
  - The detector keeps a 2-bit history plus a fill count (0..2).
  - det_hit is combinational (Mealy): 1 when fill==2 and {history, bit} is 3'b101 or 3'b110.
  - Overlapping matches count.
  - A clear resets history and fill, so no match spans a frame boundary.
- Requesters must hold req_valid and req_data until they see req_ready. The block does not check this.

## Timing
- Reset values: req_ready=0, res_valid=0, res_id=0, res_count=0, busy=0, state=IDLE, last_grant=NUM_REQ-1 (requester 0 has priority first), detector history and fill cleared.
- Cycle numbering, with the accept at cycle T:
  - CLEAR at T+1.
  - Bits shift at T+2..T+1+FRAME_W.
  - res_valid first high at T+2+FRAME_W.
- Throughput: minimum FRAME_W+3 cycles per frame when res_ready is tied high.
- Back-pressure: while res_ready=0, DONE holds indefinitely, and no req_ready is asserted.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that is not granted keeps waiting.
- Reset mid-frame: asynchronous return to IDLE and the in-flight frame is dropped with no result. The accepted frame is not re-requested.
- Arithmetic: the increment never wraps; it is clamped at the all-ones value.

## Structure
- A shared package holds the state enum (IDLE, CLEAR, SHIFT, DONE) and the pattern constants 3'b101 and 3'b110.
- One sub-module, seq101_110_det: ports clk, rst_n, clr, din, hit. It holds the 2-bit history, fill count and Mealy hit logic.
- The top level holds the arbiter pointer, shift register, bit counter, saturating counter and FSM.

## Test plan
- Single frame, defaults: requester 0 sends 8'b1011_0110 -> req_ready[0] pulses at T, and res_valid rises at T+10 with res_id=0, res_count=4.
- Alternating pattern, then a boundary pair:
  - Requester 2 sends 8'b1010_1010 -> res_count=3.
  - Requester 1 then sends 8'hFF followed by 8'h00 -> each gives res_count=0 (no detection across the frame boundary).
- Round-robin: all four req_valid held high -> grant order 0,1,2,3,0, with exactly one req_ready bit high per grant.
- Saturation: with CNT_W=2, 8'b1011_0110 -> res_count=3.
- Back-pressure: res_ready=0 for 20 cycles -> res_valid, res_id and res_count stay stable, busy=1, and no req_ready is asserted. On release, the result is consumed in one cycle.
- Reset mid-operation: deassert rst_n during SHIFT -> all outputs take reset values immediately and no result is produced. After release, requester 0 wins first.

Source files
------------

// File: rtl/seq_det_scheduler_pkg.sv
// Shared types and constants for the round-robin detector scheduler.
package seq_det_scheduler_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The two 3-bit windows the detector reports as hits.
  localparam logic [2:0] PAT_A = 3'b101;
  localparam logic [2:0] PAT_B = 3'b110;

endpackage : seq_det_scheduler_pkg

// File: rtl/seq_det_scheduler_if.sv
// Frame request / result handshake bundle between the sources, the scheduler and the result consumer.
interface seq_det_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*FRAME_W-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       res_valid;
  logic [ID_W-1:0]            res_id;
  logic [CNT_W-1:0]           res_count;
  logic                       res_ready;

  // Frame sources plus result consumer.
  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_count
  );

  // The scheduler.
  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_count
  );
endinterface : seq_det_scheduler_if

// File: rtl/seq_det_scheduler_det.sv
// Serial 101/110 detector: 2-bit history, fill count, Mealy hit, synchronous clear.
module seq101_110_det
  import seq_det_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic hit
);

  logic [1:0] r_hist;
  logic [1:0] r_fill;
  logic [2:0] w_win;

  // Mealy hit: only a full history plus the current bit forms a valid window.
  always_comb begin
    w_win = {r_hist, din};
    hit   = (r_fill == 2'd2) && ((w_win == PAT_A) || (w_win == PAT_B));
  end

  // History and fill; clear empties both so no window spans two frames.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      r_hist <= {r_hist[0], din};
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
    end
  end

endmodule : seq101_110_det

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one 101/110 detector among NUM_REQ frame sources.
module seq_det_scheduler
  import seq_det_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_det_scheduler_if.slave  bus,
  output logic                busy
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(FRAME_W - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             r_state, w_next;
  logic [ID_W-1:0]    r_last_grant, r_grant_id, w_grant;
  logic               w_found;
  logic [FRAME_W-1:0] r_shift;
  logic [BC_W-1:0]    r_bit_cnt;
  logic [CNT_W-1:0]   r_count;
  logic               w_det_clr, w_hit;
  logic [FRAME_W-1:0] w_frames [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_frames
    assign w_frames[gi] = bus.req_data[gi*FRAME_W +: FRAME_W];
  end

  // Round-robin search: first valid requester after the last grant, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[ID_W'(idx)]) begin
        w_grant = ID_W'(idx);
        w_found = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = CLEAR;
      CLEAR:   w_next = SHIFT;
      SHIFT:   if (r_bit_cnt == LAST_BIT) w_next = DONE;
      DONE:    if (bus.res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs; the grant strobe is withheld while reset is asserted since nothing can be captured then.
  always_comb begin
    bus.req_ready = '0;
    bus.res_valid = 1'b0;
    w_det_clr     = 1'b0;
    busy          = (r_state != IDLE);
    case (r_state)
      IDLE:    if (w_found && rst_n) bus.req_ready[w_grant] = 1'b1;
      CLEAR:   w_det_clr = 1'b1;
      DONE:    bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.res_id    = r_grant_id;
  assign bus.res_count = r_count;

  // Datapath: frame capture, MSB-first shifting, bit counter, saturating hit count, arbiter pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= LAST_ID;
      r_grant_id   <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_shift    <= w_frames[w_grant];
          r_grant_id <= w_grant;
          r_count    <= '0;
          r_bit_cnt  <= '0;
        end
        SHIFT: begin
          r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_hit && (r_count != CNT_MAX)) r_count <= r_count + 1'b1;
        end
        DONE: if (bus.res_ready) r_last_grant <= r_grant_id;
        default: ;
      endcase
    end
  end

  // The shared detector sees the current MSB every cycle; hits only count in SHIFT.
  seq101_110_det u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_det_clr),
    .din   (r_shift[FRAME_W-1]),
    .hit   (w_hit)
  );

endmodule : seq_det_scheduler
